pr_arbiter_ctrl: RTL and testbench
==================================

PR_ARBITER_CTRL -- requirements
Module: pr_arbiter_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning: maximum consecutive cycles one requester may hold the grant (legal range 2..256).
REQ-002 Port clk  input  1  clock; all state changes on the rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port req  input  8  request lines; bit i is requester i.
REQ-005 Port done  input  1  the current grant owner releases the resource this cycle.
REQ-006 Port rr_mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-007 Port gnt  output  8  one-hot grant vector, registered.
REQ-008 Port gnt_id  output  3  binary index of the granted requester, registered.
REQ-009 Port gnt_valid  output  1  high while any grant is held, registered.
REQ-010 Port timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-011 The block SHALL implement the three states IDLE, GRANT and GAP.
REQ-012 IDLE: if req != 0 at the edge, the block SHALL latch the winner, enter GRANT, and assert gnt, gnt_id and gnt_valid after that same edge (latency 1 cycle from sampled request to grant).
REQ-013 IDLE with req == 0: the block SHALL stay in IDLE with gnt = 0, gnt_id = 0 and gnt_valid = 0.
REQ-014 Fixed priority (rr_mode=0): the highest set index SHALL win (bit 7 highest, bit 0 lowest).
REQ-015 Round-robin (rr_mode=1): the search SHALL start at index (last_id - 1) mod 8 and descend with wrap-around from 0 to 7; the first set bit found SHALL win.
REQ-016 last_id SHALL update to the winner on every grant in both modes; its reset value SHALL be 0, so the first round-robin search starts at index 7.
REQ-017 rr_mode SHALL be sampled only in IDLE; a change during GRANT or GAP SHALL NOT affect the current grant.
REQ-018 GRANT: an 8-bit hold counter SHALL be cleared on grant entry and SHALL increment each cycle spent in GRANT.
REQ-019 GRANT exit conditions, any of which moves the block to GAP at the next edge:
- done = 1;
- req[gnt_id] = 0;
- hold counter = MAX_HOLD-1.
REQ-020 If the exit is caused only by the hold counter (done = 0 and req[gnt_id] = 1), timeout SHALL pulse high for exactly the one cycle the block spends in GAP.
REQ-021 If done = 1 coincides with the hold limit, the release SHALL count as normal and timeout SHALL stay 0.
REQ-022 GAP: gnt = 0, gnt_valid = 0, gnt_id = 0 for exactly one cycle, then the block SHALL enter IDLE unconditionally.
REQ-023 Requests from other requesters during GRANT SHALL be ignored; only IDLE arbitrates.
REQ-024 gnt SHALL always equal 1 << gnt_id when gnt_valid = 1, and 0 otherwise; gnt SHALL never have more than one bit set.
REQ-025 done asserted while in IDLE or GAP SHALL be ignored.
REQ-026 A requester that holds req high continuously SHALL be re-granted at most once per GRANT+GAP+IDLE cycle; in round-robin mode other pending requesters SHALL be served first.

Reset
REQ-027 rst_n low SHALL, asynchronously and without waiting for a clock edge, force state = IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, hold counter = 0 and last_id = 0.
REQ-028 Reset asserted mid-GRANT SHALL drop the grant immediately with no GAP cycle and no timeout pulse.
REQ-029 After rst_n rises, the first arbitration SHALL occur at the first rising edge on which rst_n is high and req != 0.

Verification
REQ-030 Fixed mode, req=8'b0010_1100 held, done pulsed after 3 cycles -> gnt=8'b0010_0000, gnt_id=5, gnt_valid=1 the cycle after req; one GAP cycle after done; next grant is again id 5.
REQ-031 Round-robin, req=8'hFF held, done pulsed every grant -> grant order 7,6,5,...,0,7, each grant separated by one GAP cycle.
REQ-032 MAX_HOLD=4, req=8'h01 held, done=0 -> gnt_id=0 valid for exactly 4 cycles, timeout=1 for 1 cycle with gnt=0, then regrant to id 0.
REQ-033 done=1 on the same cycle the hold counter reaches MAX_HOLD-1 -> release to GAP with timeout=0.
REQ-034 Owner drops req[gnt_id] while req=8'h81 in fixed mode -> GAP, then grant id 7 even if bit 0 was the previous owner.
REQ-035 rst_n pulled low mid-GRANT, between clock edges -> all outputs 0 immediately; after release, req=8'h10 -> gnt_id=4 one cycle later.

Source files
------------

// File: rtl/pr_arbiter_ctrl.sv
// Single-resource arbiter for eight requesters with fixed-priority or round-robin selection.
// Each grant is followed by one GAP cycle; a hold limit force-releases a grant that never lets go.
module pr_arbiter_ctrl #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       rr_mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [2:0] last_id, last_nxt;
    logic [2:0] id_nxt;
    logic [7:0] gnt_nxt;
    logic       valid_nxt;
    logic       timeout_nxt;

    logic [2:0] search_start;
    logic [2:0] winner;
    logic [2:0] probe;
    logic       hit_limit;
    logic       owner_req;
    logic       release_now;

    // Fixed priority is a descending search from 7; round-robin starts just below the last winner.
    assign search_start = rr_mode ? (last_id - 3'd1) : 3'd7;

    always_comb begin
        winner = 3'd0;
        probe  = 3'd0;
        // Walk from the far end so the closest set bit to search_start is assigned last and wins.
        for (int k = 7; k >= 0; k--) begin
            probe = search_start - 3'(k);
            if (req[probe]) begin
                winner = probe;
            end
        end
    end

    assign hit_limit   = (hold_cnt == HOLD_LAST);
    assign owner_req   = req[gnt_id];
    assign release_now = done || !owner_req || hit_limit;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        last_nxt    = last_id;
        id_nxt      = 3'd0;
        gnt_nxt     = 8'd0;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                hold_nxt = 8'd0;
                if (|req) begin
                    state_nxt = GRANT;
                    id_nxt    = winner;
                    gnt_nxt   = 8'd1 << winner;
                    valid_nxt = 1'b1;
                    last_nxt  = winner;
                end
            end

            GRANT: begin
                if (release_now) begin
                    state_nxt   = GAP;
                    hold_nxt    = 8'd0;
                    // A release that coincides with done or a dropped request is a normal release.
                    timeout_nxt = hit_limit && !done && owner_req;
                end else begin
                    hold_nxt  = hold_cnt + 8'd1;
                    id_nxt    = gnt_id;
                    gnt_nxt   = gnt;
                    valid_nxt = 1'b1;
                end
            end

            GAP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            last_id   <= 3'd0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            last_id   <= last_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= id_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_pr_arbiter_ctrl.sv
// Scoreboard bench for pr_arbiter_ctrl: stimulus pushes the expected grant sequence,
// a monitor pops and compares each grant as it appears on the outputs.
module tb_pr_arbiter_ctrl;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       rr_mode = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] id;
        int         len;   // expected cycles with gnt_valid high, 0 = not checked
        logic       tmo;   // expected timeout in the GAP cycle
        int         gap;   // expected low cycles before this grant, 0 = not checked
    } exp_t;

    exp_t sb[$];

    pr_arbiter_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input logic v, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (gnt_valid == v) return;
            @(negedge clk);
        end
        check("wait_valid", {31'd0, gnt_valid}, {31'd0, v});
    endtask

    task automatic expect_grant(input logic [2:0] id, input int len, input logic tmo, input int gap);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.tmo = tmo;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // how: 0 = pulse done in cycle len, 1 = let the hold limit expire, 2 = drive req to nreq in cycle len
    task automatic drive_grant(input int len, input int how, input logic [7:0] nreq);
        wait_valid(1'b1, 20);
        if (how != 1) begin
            repeat (len - 1) @(negedge clk);
            if (how == 0) done = 1'b1;
            else req = nreq;
            @(negedge clk);
            done = 1'b0;
        end
        wait_valid(1'b0, 300);
    endtask

    task automatic serve(input logic [2:0] id, input int len, input int how,
                         input logic [7:0] nreq, input int gap);
        expect_grant(id, len, (how == 1), gap);
        drive_grant(len, how, nreq);
    endtask

    // Monitor state
    logic mon_in_grant = 1'b0;
    int   mon_cnt = 0;
    int   mon_low = 0;
    exp_t mon_cur = '{id: 3'd0, len: 0, tmo: 1'b0, gap: 0};

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mon_in_grant = 1'b0;
                mon_cnt      = 0;
                mon_low      = 0;
            end else begin
                check("onehot", {24'd0, gnt}, gnt_valid ? (32'd1 << gnt_id) : 32'd0);
                if (gnt_valid && !mon_in_grant) begin
                    check("sb_pending", {31'd0, (sb.size() > 0)}, 32'd1);
                    if (sb.size() > 0) begin
                        mon_cur = sb.pop_front();
                        check("gnt_id", {29'd0, gnt_id}, {29'd0, mon_cur.id});
                        if (mon_cur.gap > 0) check("gap_len", mon_low, mon_cur.gap);
                    end
                    check("timeout_busy", {31'd0, timeout}, 32'd0);
                    mon_in_grant = 1'b1;
                    mon_cnt      = 1;
                end else if (gnt_valid) begin
                    mon_cnt++;
                    check("timeout_busy", {31'd0, timeout}, 32'd0);
                end else if (mon_in_grant) begin
                    if (mon_cur.len > 0) check("hold_len", mon_cnt, mon_cur.len);
                    check("timeout_gap", {31'd0, timeout}, {31'd0, mon_cur.tmo});
                    check("gap_id", {29'd0, gnt_id}, 32'd0);
                    mon_in_grant = 1'b0;
                    mon_low      = 1;
                end else begin
                    check("timeout_idle", {31'd0, timeout}, 32'd0);
                    check("idle_id", {29'd0, gnt_id}, 32'd0);
                    mon_low++;
                end
            end
        end
    end

    initial begin : stimulus
        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", {24'd0, gnt}, 32'd0);
        check("rst_id", {29'd0, gnt_id}, 32'd0);
        check("rst_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with all requesting: 7 down to 0, then wrap to 7
        rr_mode = 1'b1;
        req     = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            serve(3'(7 - i), 1, 0, 8'h00, (i == 0) ? 0 : 2);
        end

        // Fixed priority: highest of bits 5,3,2 wins twice in a row
        rr_mode = 1'b0;
        req     = 8'h2C;
        serve(3'd5, 3, 0, 8'h00, 2);
        serve(3'd5, 3, 0, 8'h00, 2);

        // Hold limit expires, then done coincides with the limit
        req = 8'h01;
        serve(3'd0, MAX_HOLD, 1, 8'h00, 2);
        serve(3'd0, MAX_HOLD, 0, 8'h00, 2);

        // Other requests ignored during a grant; owner drop hands over to bit 7
        expect_grant(3'd0, 2, 1'b0, 2);
        wait_valid(1'b1, 20);
        req = 8'h81;
        @(negedge clk);
        req = 8'h80;
        @(negedge clk);
        wait_valid(1'b0, 20);
        serve(3'd7, 1, 0, 8'h00, 2);

        // Reset in the middle of a grant
        req = 8'h02;
        expect_grant(3'd1, 0, 1'b0, 2);
        wait_valid(1'b1, 20);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", {24'd0, gnt}, 32'd0);
        check("midrst_id", {29'd0, gnt_id}, 32'd0);
        check("midrst_valid", {31'd0, gnt_valid}, 32'd0);
        check("midrst_timeout", {31'd0, timeout}, 32'd0);
        req = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {31'd0, gnt_valid}, 32'd0);
        check("post_rst_timeout", {31'd0, timeout}, 32'd0);

        // One-cycle latency from sampled request to grant
        expect_grant(3'd4, 1, 1'b0, 0);
        req = 8'h10;
        @(posedge clk);
        #1;
        check("latency_valid", {31'd0, gnt_valid}, 32'd1);
        check("latency_id", {29'd0, gnt_id}, 32'd4);
        @(negedge clk);
        drive_grant(1, 0, 8'h00);

        // Round-robin resumes below last winner 4 and wraps through 7
        rr_mode = 1'b1;
        req     = 8'h31;
        serve(3'd0, 1, 0, 8'h00, 2);
        serve(3'd5, 1, 0, 8'h00, 2);
        serve(3'd4, 1, 0, 8'h00, 2);
        req     = 8'h00;
        rr_mode = 1'b0;

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
